// File: rtl/fifo_burst_reader_if.sv
// Purpose: bundles the fifo read port and the framed output stream of fifo_burst_reader.
// Latency: none; wires only.
// Backpressure: out_ready from the consumer gates fifo_pop inside the reader.
interface fifo_burst_reader_if #(
  parameter int bits = 8
);
  // fifo read side (first-word-fall-through head)
  logic [bits-1:0] fifo_dout;
  logic            fifo_pndng;
  logic            fifo_pop;
  // framed output stream
  logic [bits-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_sop;
  logic            out_eop;

  // reader side: consumes the fifo head, produces the stream
  modport master (
    input  fifo_dout, fifo_pndng, out_ready,
    output fifo_pop, out_data, out_valid, out_sop, out_eop
  );

  // environment side: the fifo plus the downstream consumer
  modport slave (
    output fifo_dout, fifo_pndng, out_ready,
    input  fifo_pop, out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Purpose: drains a FWFT fifo into a valid/ready stream framed as fixed-length bursts with sop/eop.
// Latency: 1 clk from fifo head to out_valid; one beat per cycle when pndng and ready stay high.
// Backpressure: single-entry output register; the fifo is popped only when that register is free.
module fifo_burst_reader #(
  parameter int bits  = 8,
  parameter int burst = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  fifo_burst_reader_if.master bus,
  output logic [7:0]          burst_done,
  output logic                busy
);

  localparam int            CW   = $clog2(burst);
  localparam logic [CW-1:0] LAST = CW'(burst - 1);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic            sop;
    logic            eop;
    logic [bits-1:0] data;
  } beat_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  beat_t           beat_q;
  logic            valid_q;
  logic            slot_free;
  logic            load;
  logic            accept;

  // The output register can take a new word if it is empty or being drained this cycle.
  // en only matters when deciding to open a new burst; an open burst always runs to eop.
  assign slot_free = !valid_q || bus.out_ready;
  assign load      = bus.fifo_pndng && slot_free && (state == BURST || en);
  assign accept    = valid_q && bus.out_ready;

  // Pop and capture happen on the same edge, so pop never fires on an empty fifo.
  // Held low during reset so nothing is consumed while the reader is being cleared.
  assign bus.fifo_pop  = load && !rst;
  assign bus.out_data  = beat_q.data;
  assign bus.out_sop   = beat_q.sop;
  assign bus.out_eop   = beat_q.eop;
  assign bus.out_valid = valid_q;
  assign busy          = (state == BURST) || valid_q;

  // Burst framing FSM and output register: load a beat, or retire an accepted one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
    end else if (load) begin
      beat_q.data <= bus.fifo_dout;
      beat_q.sop  <= (beat_cnt == '0);
      beat_q.eop  <= (beat_cnt == LAST);
      valid_q     <= 1'b1;
      if (beat_cnt == LAST) begin
        beat_cnt <= '0;
        state    <= IDLE;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        state    <= BURST;
      end
    end else if (accept) begin
      // Data is left as-is; only the qualifiers drop. An underflow keeps state and count.
      valid_q    <= 1'b0;
      beat_q.sop <= 1'b0;
      beat_q.eop <= 1'b0;
    end
  end

  // Count bursts whose final beat was taken by the consumer; wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_done <= 8'd0;
    end else if (accept && beat_q.eop) begin
      burst_done <= burst_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a burst=4 instance driven from a queue-modelled fifo,
// and a burst=2 instance fed from a counting source for the sop/eop alternation and
// burst_done wrap. Expected beats are queued at stimulus time and checked by a monitor.
module tb_fifo_burst_reader;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a;
  logic       en_b;
  logic [7:0] burst_done_a;
  logic [7:0] burst_done_b;
  logic       busy_a;
  logic       busy_b;

  fifo_burst_reader_if #(.bits(8)) ifa ();
  fifo_burst_reader_if #(.bits(8)) ifb ();

  fifo_burst_reader #(.bits(8), .burst(4)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .bus(ifa),
    .burst_done(burst_done_a), .busy(busy_a)
  );

  fifo_burst_reader #(.bits(8), .burst(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .bus(ifb),
    .burst_done(burst_done_b), .busy(busy_b)
  );

  // posedge at 5 mod 10, negedge at 0 mod 10; inputs change on negedge, sampling at +3
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  beat_t      exp_a[$];
  beat_t      exp_b[$];
  logic [7:0] fq_a[$];
  int         pops_a = 0;
  int         acc_a  = 0;
  int         acc_b  = 0;
  int         src_b  = 0;
  int         src_lim_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic sop, input logic eop);
    fq_a.push_back(d);
    exp_a.push_back('{d, sop, eop});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // fifo model A: head presented at negedge+1, pop observed at negedge+3 (before the edge)
  initial begin
    ifa.fifo_pndng = 1'b0;
    ifa.fifo_dout  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      ifa.fifo_pndng = (fq_a.size() != 0);
      ifa.fifo_dout  = (fq_a.size() != 0) ? fq_a[0] : 8'h00;
      #2;
      if (ifa.fifo_pop) begin
        pops_a++;
        if (fq_a.size() != 0) void'(fq_a.pop_front());
      end
    end
  end

  // source B: an endless counting fifo, limited by src_lim_b words
  initial begin
    ifb.fifo_pndng = 1'b0;
    ifb.fifo_dout  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      ifb.fifo_pndng = (src_b < src_lim_b);
      ifb.fifo_dout  = 8'(src_b);
      #2;
      if (ifb.fifo_pop) src_b++;
    end
  end

  // monitor: every accepted beat is popped from the scoreboard and compared
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (ifa.out_valid && ifa.out_ready) begin
        acc_a++;
        check("a_beat_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check("a_beat{data,sop,eop}", 32'({ifa.out_data, ifa.out_sop, ifa.out_eop}), 32'(e));
        end
      end
      if (ifb.out_valid && ifb.out_ready) begin
        acc_b++;
        check("b_beat_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check("b_beat{data,sop,eop}", 32'({ifb.out_data, ifb.out_sop, ifb.out_eop}), 32'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got t=%0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0;
    int p0;
    int to;
    rst = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    cyc(2);

    // reset state
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_out_data",  32'(ifa.out_data),  32'd0);
    check("rst_out_sop",   32'(ifa.out_sop),   32'd0);
    check("rst_out_eop",   32'(ifa.out_eop),   32'd0);
    check("rst_burst_done", 32'(burst_done_a), 32'd0);
    check("rst_busy",      32'(busy_a),        32'd0);
    rst = 1'b0;

    // streaming 0x10..0x17: two back-to-back bursts, no bubbles
    @(negedge clk);
    a0 = acc_a;
    p0 = pops_a;
    en_a = 1'b1;
    for (int i = 0; i < 8; i++) push_a(8'(8'h10 + i), (i % 4) == 0, (i % 4) == 3);
    cyc(8);
    #4;
    check("stream_beats_in_8_cycles", 32'(acc_a - a0), 32'd8);
    check("stream_pop_cycles", 32'(pops_a - p0), 32'd8);
    @(negedge clk);
    #4;
    check("stream_burst_done", 32'(burst_done_a), 32'd2);
    check("stream_busy_idle",  32'(busy_a), 32'd0);
    check("stream_valid_idle", 32'(ifa.out_valid), 32'd0);

    // back-pressure: stall 3 cycles while 0x21 is presented
    @(negedge clk);
    push_a(8'h20, 1'b1, 1'b0);
    push_a(8'h21, 1'b0, 1'b0);
    push_a(8'h22, 1'b0, 1'b0);
    push_a(8'h23, 1'b0, 1'b1);
    cyc(2);
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      check("bp_valid", 32'(ifa.out_valid), 32'd1);
      check("bp_data",  32'(ifa.out_data), 32'h21);
      check("bp_sop",   32'(ifa.out_sop), 32'd0);
      check("bp_pop",   32'(ifa.fifo_pop), 32'd0);
      @(negedge clk);
    end
    ifa.out_ready = 1'b1;
    cyc(6);
    #4;
    check("bp_burst_done", 32'(burst_done_a), 32'd3);
    check("bp_all_beats_seen", 32'(exp_a.size()), 32'd0);

    // underflow mid-burst: two words, then two more five cycles later
    @(negedge clk);
    push_a(8'hA0, 1'b1, 1'b0);
    push_a(8'hA1, 1'b0, 1'b0);
    exp_a.push_back('{8'hA2, 1'b0, 1'b0});
    exp_a.push_back('{8'hA3, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #4;
      check("uf_busy", 32'(busy_a), 32'd1);
      if (i >= 2) check("uf_gap_valid", 32'(ifa.out_valid), 32'd0);
    end
    @(negedge clk);
    fq_a.push_back(8'hA2);
    fq_a.push_back(8'hA3);
    cyc(5);
    #4;
    check("uf_burst_done", 32'(burst_done_a), 32'd4);
    check("uf_busy_end", 32'(busy_a), 32'd0);
    check("uf_all_beats_seen", 32'(exp_a.size()), 32'd0);

    // enable gating: en dropped after the first beat; next burst waits for en
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_a(8'(8'hB0 + i), i == 0, i == 3);
    for (int i = 0; i < 4; i++) push_a(8'(8'hC0 + i), i == 0, i == 3);
    @(negedge clk);
    en_a = 1'b0;
    cyc(3);
    for (int k = 0; k < 3; k++) begin
      #3;
      check("en_off_pop", 32'(ifa.fifo_pop), 32'd0);
      if (k > 0) check("en_off_valid", 32'(ifa.out_valid), 32'd0);
      if (k == 1) check("en_off_burst_done", 32'(burst_done_a), 32'd5);
      @(negedge clk);
    end
    en_a = 1'b1;
    #13;
    check("en_on_valid", 32'(ifa.out_valid), 32'd1);
    check("en_on_sop",   32'(ifa.out_sop), 32'd1);
    check("en_on_data",  32'(ifa.out_data), 32'hC0);
    @(negedge clk);
    cyc(6);
    #4;
    check("en_burst_done", 32'(burst_done_a), 32'd6);
    check("en_all_beats_seen", 32'(exp_a.size()), 32'd0);

    // reset mid-burst: asynchronous clear, popped words lost
    @(negedge clk);
    push_a(8'hD0, 1'b1, 1'b0);
    fq_a.push_back(8'hD1);
    fq_a.push_back(8'hD2);
    fq_a.push_back(8'hD3);
    cyc(2);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out_valid",  32'(ifa.out_valid), 32'd0);
    check("arst_fifo_pop",   32'(ifa.fifo_pop), 32'd0);
    check("arst_burst_done", 32'(burst_done_a), 32'd0);
    check("arst_busy",       32'(busy_a), 32'd0);
    check("arst_out_sop",    32'(ifa.out_sop), 32'd0);
    @(negedge clk);
    fq_a.delete();
    @(negedge clk);
    rst = 1'b0;
    check("arst_all_beats_seen", 32'(exp_a.size()), 32'd0);

    // after reset a fresh burst starts with sop on its first word
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_a(8'(8'hE0 + i), i == 0, i == 3);
    cyc(6);
    #4;
    check("post_rst_burst_done", 32'(burst_done_a), 32'd1);
    check("post_rst_all_beats_seen", 32'(exp_a.size()), 32'd0);

    // burst=2: sop/eop alternate every beat; 256 bursts wrap burst_done to 0
    @(negedge clk);
    en_b = 1'b1;
    for (int i = 0; i < 512; i++) exp_b.push_back('{8'(i), (i % 2) == 0, (i % 2) == 1});
    src_lim_b = 512;
    to = 0;
    while (acc_b < 20 && to < 200) begin
      @(negedge clk);
      #4;
      to++;
    end
    #2;
    check("wrap_mid_burst_done", 32'(burst_done_b), 32'd10);
    to = 0;
    while (acc_b < 512 && to < 2000) begin
      @(negedge clk);
      #4;
      to++;
    end
    @(negedge clk);
    #4;
    check("wrap_beats_accepted", 32'(acc_b), 32'd512);
    check("wrap_burst_done", 32'(burst_done_b), 32'd0);
    check("wrap_all_beats_seen", 32'(exp_b.size()), 32'd0);
    check("wrap_busy_idle", 32'(busy_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
